// File: rtl/issue_scoreboard_ctrl.sv
// ID-stage issue controller: per-GPR pending-write scoreboard, serialisation and redirect flush.
// Optional SCB_WB_BYPASS_EN lets a source issue in the cycle its last pending write retires.
module issue_scoreboard_ctrl #(
  parameter int CNT_W        = 2,
  parameter int MAX_INFLIGHT = 4,
  parameter int REDIRECT_CYC = 1,
  localparam int IW          = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          IF_ID_reg_inst_valid,
  input  logic [4:0]    rs1,
  input  logic          rs1_valid,
  input  logic [4:0]    rs2,
  input  logic          rs2_valid,
  input  logic [4:0]    id_rd,
  input  logic          id_dest_wen,
  input  logic          id_serial,
  input  logic          EX_reg_execute_enable,
  input  logic          ex_redirect,
  input  logic          wb_valid,
  input  logic [4:0]    wb_rd,
  input  logic          wb_dest_wen,
  output logic          ID_reg_decode_enable,
  output logic          ID_reg_decode_flush,
  output logic          MON_ID_src_block_flag,
  output logic          issue_fire,
  output logic [IW-1:0] inflight_cnt,
  output logic          scb_err
);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_SERIAL,
    ST_REDIR
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q [32];
  logic [CNT_W-1:0]  cnt_d [32];
  logic [IW-1:0]     inflight_q, inflight_d;
  logic [2:0]        rcnt_q, rcnt_d;
  logic              err_q, err_d;

  logic rs1_hit, rs2_hit, rs1_byp, rs2_byp;
  logic block_raw, block_str;
  logic inc_en, dec_en, inf_dec, cnt_uf;

  always_comb begin
    rs1_hit = rs1_valid & (rs1 != 5'd0) & (cnt_q[rs1] != '0);
    rs2_hit = rs2_valid & (rs2 != 5'd0) & (cnt_q[rs2] != '0);
`ifdef SCB_WB_BYPASS_EN
    rs1_byp = wb_valid & wb_dest_wen & (wb_rd == rs1)
            & (cnt_q[rs1] == CNT_W'(1));
    rs2_byp = wb_valid & wb_dest_wen & (wb_rd == rs2)
            & (cnt_q[rs2] == CNT_W'(1));
`else
    rs1_byp = 1'b0;
    rs2_byp = 1'b0;
`endif
    block_raw = (rs1_hit & ~rs1_byp) | (rs2_hit & ~rs2_byp);
    block_str = (id_dest_wen & (id_rd != 5'd0) & (cnt_q[id_rd] == '1))
              | (inflight_q == IW'(MAX_INFLIGHT))
              | (id_serial & (inflight_q != '0));
  end

  always_comb begin
    MON_ID_src_block_flag = IF_ID_reg_inst_valid
                          & (block_raw | block_str | (state_q == ST_SERIAL));
    issue_fire = IF_ID_reg_inst_valid & ~MON_ID_src_block_flag
               & EX_reg_execute_enable & (state_q == ST_RUN) & ~ex_redirect;
    ID_reg_decode_enable = EX_reg_execute_enable & (state_q != ST_REDIR);
    ID_reg_decode_flush  = ex_redirect | (state_q == ST_REDIR);
    inflight_cnt = inflight_q;
    scb_err      = err_q;
  end

  // A retire with nothing in flight is dropped entirely, counters included.
  always_comb begin
    inf_dec = wb_valid & (inflight_q != '0);
    inc_en  = issue_fire & id_dest_wen & (id_rd != 5'd0);
    dec_en  = inf_dec & wb_dest_wen & (wb_rd != 5'd0);
    cnt_uf  = 1'b0;
    for (int i = 0; i < 32; i++) begin
      cnt_d[i] = cnt_q[i];
    end
    for (int i = 1; i < 32; i++) begin
      if ((inc_en & (id_rd == 5'(i))) & ~(dec_en & (wb_rd == 5'(i)))) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end else if (~(inc_en & (id_rd == 5'(i))) & dec_en
                   & (wb_rd == 5'(i))) begin
        if (cnt_q[i] == '0) begin
          cnt_uf = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] - CNT_W'(1);
        end
      end
    end
    inflight_d = inflight_q;
    if (issue_fire & ~inf_dec) begin
      inflight_d = inflight_q + IW'(1);
    end else if (~issue_fire & inf_dec) begin
      inflight_d = inflight_q - IW'(1);
    end
    err_d = err_q | cnt_uf | (wb_valid & (inflight_q == '0));
  end

  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    if (ex_redirect) begin
      state_d = ST_REDIR;
      rcnt_d  = 3'(REDIRECT_CYC - 1);
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (issue_fire & id_serial) state_d = ST_SERIAL;
        end
        ST_SERIAL: begin
          if (inflight_d == '0) state_d = ST_RUN;
        end
        ST_REDIR: begin
          if (rcnt_q == 3'd0) state_d = ST_RUN;
          else rcnt_d = rcnt_q - 3'd1;
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_RUN;
      inflight_q <= '0;
      rcnt_q     <= 3'd0;
      err_q      <= 1'b0;
      for (int i = 0; i < 32; i++) cnt_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      inflight_q <= inflight_d;
      rcnt_q     <= rcnt_d;
      err_q      <= err_d;
      for (int i = 0; i < 32; i++) cnt_q[i] <= cnt_d[i];
    end
  end

endmodule

// File: tb/tb_issue_scoreboard_ctrl.sv
// Directed table-driven bench for issue_scoreboard_ctrl (REDIRECT_CYC=2).
module tb_issue_scoreboard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       v, r1v, r2v, dw, ser, exen, redir, wbv, wbw;
  logic [4:0] rs1, rs2, rd, wbrd;
  logic       dec_en, dec_fl, blk, fire, err;
  logic [2:0] inflight;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  issue_scoreboard_ctrl #(.REDIRECT_CYC(2)) dut (
    .clk(clk), .rst(rst),
    .IF_ID_reg_inst_valid(v),
    .rs1(rs1), .rs1_valid(r1v),
    .rs2(rs2), .rs2_valid(r2v),
    .id_rd(rd), .id_dest_wen(dw), .id_serial(ser),
    .EX_reg_execute_enable(exen),
    .ex_redirect(redir),
    .wb_valid(wbv), .wb_rd(wbrd), .wb_dest_wen(wbw),
    .ID_reg_decode_enable(dec_en),
    .ID_reg_decode_flush(dec_fl),
    .MON_ID_src_block_flag(blk),
    .issue_fire(fire),
    .inflight_cnt(inflight),
    .scb_err(err)
  );

  typedef struct {
    logic       v;
    logic [4:0] rs1;
    logic       r1v;
    logic [4:0] rs2;
    logic       r2v;
    logic [4:0] rd;
    logic       dw;
    logic       ser;
    logic       exen;
    logic       redir;
    logic       wbv;
    logic [4:0] wbrd;
    logic       wbw;
    logic       e_en;
    logic       e_fl;
    logic       e_blk;
    logic       e_fire;
    logic [2:0] e_inf;
    logic       e_err;
  } vec_t;

  function automatic vec_t mk(
    input logic a_v, input logic [4:0] a_rs1, input logic a_r1v,
    input logic [4:0] a_rs2, input logic a_r2v,
    input logic [4:0] a_rd, input logic a_dw, input logic a_ser,
    input logic a_exen, input logic a_redir,
    input logic a_wbv, input logic [4:0] a_wbrd, input logic a_wbw,
    input logic x_en, input logic x_fl, input logic x_blk,
    input logic x_fire, input logic [2:0] x_inf, input logic x_err);
    vec_t t;
    t.v = a_v; t.rs1 = a_rs1; t.r1v = a_r1v;
    t.rs2 = a_rs2; t.r2v = a_r2v;
    t.rd = a_rd; t.dw = a_dw; t.ser = a_ser;
    t.exen = a_exen; t.redir = a_redir;
    t.wbv = a_wbv; t.wbrd = a_wbrd; t.wbw = a_wbw;
    t.e_en = x_en; t.e_fl = x_fl; t.e_blk = x_blk;
    t.e_fire = x_fire; t.e_inf = x_inf; t.e_err = x_err;
    return t;
  endfunction

  task automatic apply(input vec_t t, input string nm);
    logic [7:0] act, exp;
    v = t.v; rs1 = t.rs1; r1v = t.r1v;
    rs2 = t.rs2; r2v = t.r2v;
    rd = t.rd; dw = t.dw; ser = t.ser;
    exen = t.exen; redir = t.redir;
    wbv = t.wbv; wbrd = t.wbrd; wbw = t.wbw;
    #3;
    act = {dec_en, dec_fl, blk, fire, inflight, err};
    exp = {t.e_en, t.e_fl, t.e_blk, t.e_fire, t.e_inf, t.e_err};
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: en/fl/blk/fire/inf/err got %b want %b",
               nm, act, exp);
    end
    @(posedge clk);
    #1;
  endtask

  vec_t tbl [37];
  vec_t idle;

  initial begin
    //            v rs1 r1 rs2 r2 rd dw sr ex rd wv wrd ww  en fl bk fi inf er
    tbl[0]  = mk(0, 0,0, 0,0,  0,0,0,0,0, 0, 0,0, 0,0,0,0,0,0);
    tbl[1]  = mk(1, 0,0, 0,0,  7,1,0,1,0, 0, 0,0, 1,0,0,1,0,0);
    tbl[2]  = mk(1, 0,0, 0,0,  7,1,0,1,0, 0, 0,0, 1,0,0,1,1,0);
    tbl[3]  = mk(1, 0,0, 0,0,  7,1,0,1,0, 0, 0,0, 1,0,0,1,2,0);
    tbl[4]  = mk(1, 0,0, 0,0,  7,1,0,1,0, 0, 0,0, 1,0,1,0,3,0);
    tbl[5]  = mk(1, 0,0, 0,0,  8,1,0,1,0, 0, 0,0, 1,0,0,1,3,0);
    tbl[6]  = mk(1, 0,0, 0,0,  9,1,0,1,0, 0, 0,0, 1,0,1,0,4,0);
    tbl[7]  = mk(1, 0,0, 0,0,  0,0,0,1,0, 0, 0,0, 1,0,1,0,4,0);
    tbl[8]  = mk(0, 0,0, 0,0,  0,0,0,1,0, 1, 7,1, 1,0,0,0,4,0);
    tbl[9]  = mk(0, 0,0, 0,0,  0,0,0,1,0, 1, 7,1, 1,0,0,0,3,0);
    tbl[10] = mk(0, 0,0, 0,0,  0,0,0,1,0, 1, 7,1, 1,0,0,0,2,0);
    tbl[11] = mk(0, 0,0, 0,0,  0,0,0,1,0, 1, 8,1, 1,0,0,0,1,0);
    tbl[12] = mk(1, 0,0, 0,0,  9,1,0,1,0, 0, 0,0, 1,0,0,1,0,0);
    tbl[13] = mk(1, 0,0, 0,0,  9,1,0,1,0, 1, 9,1, 1,0,0,1,1,0);
    tbl[14] = mk(1, 9,1, 0,0,  0,0,0,1,0, 0, 0,0, 1,0,1,0,1,0);
    tbl[15] = mk(0, 0,0, 0,0,  0,0,0,1,0, 1, 9,1, 1,0,0,0,1,0);
    tbl[16] = mk(1, 9,1, 0,0,  0,0,0,1,0, 0, 0,0, 1,0,0,1,0,0);
    tbl[17] = mk(0, 0,0, 0,0,  0,0,0,1,0, 1, 0,0, 1,0,0,0,1,0);
    tbl[18] = mk(1, 0,0, 0,0, 10,1,0,1,0, 0, 0,0, 1,0,0,1,0,0);
    tbl[19] = mk(1, 0,0, 0,0, 11,1,0,1,0, 0, 0,0, 1,0,0,1,1,0);
    tbl[20] = mk(1, 0,0, 0,0, 12,1,1,1,0, 0, 0,0, 1,0,1,0,2,0);
    tbl[21] = mk(1, 0,0, 0,0, 12,1,1,1,0, 1,10,1, 1,0,1,0,2,0);
    tbl[22] = mk(1, 0,0, 0,0, 12,1,1,1,0, 1,11,1, 1,0,1,0,1,0);
    tbl[23] = mk(1, 0,0, 0,0, 12,1,1,1,0, 0, 0,0, 1,0,0,1,0,0);
    tbl[24] = mk(1, 0,0, 0,0, 13,1,0,1,0, 0, 0,0, 1,0,1,0,1,0);
    tbl[25] = mk(1, 0,0, 0,0, 13,1,0,1,0, 1,12,1, 1,0,1,0,1,0);
    tbl[26] = mk(1, 0,0, 0,0, 13,1,0,1,0, 0, 0,0, 1,0,0,1,0,0);
    tbl[27] = mk(1,13,1, 0,0, 14,1,0,1,1, 0, 0,0, 1,1,1,0,1,0);
    tbl[28] = mk(1,13,1, 0,0, 14,1,0,1,0, 1,13,1, 0,1,1,0,1,0);
    tbl[29] = mk(1,13,1, 0,0, 14,1,0,1,0, 0, 0,0, 0,1,0,0,0,0);
    tbl[30] = mk(1,13,1, 0,0, 14,1,0,1,0, 0, 0,0, 1,0,0,1,0,0);
    tbl[31] = mk(0, 0,0, 0,0,  0,0,0,1,0, 1,14,1, 1,0,0,0,1,0);
    tbl[32] = mk(0, 0,0, 0,0,  0,0,0,1,0, 1,20,1, 1,0,0,0,0,0);
    tbl[33] = mk(0, 0,0, 0,0,  0,0,0,1,0, 0, 0,0, 1,0,0,0,0,1);
    tbl[34] = mk(1,20,1, 0,0,  0,0,0,1,0, 0, 0,0, 1,0,0,1,0,1);
    tbl[35] = mk(0, 0,0, 0,0,  0,0,0,1,0, 1, 0,0, 1,0,0,0,1,1);
    tbl[36] = mk(1, 0,0, 0,0, 15,1,0,0,0, 0, 0,0, 0,0,0,0,0,1);
    idle    = mk(0, 0,0, 0,0,  0,0,0,0,0, 0, 0,0, 0,0,0,0,0,0);

    rst = 1'b1;
    v = 0; rs1 = 0; r1v = 0; rs2 = 0; r2v = 0; rd = 0; dw = 0;
    ser = 0; exen = 0; redir = 0; wbv = 0; wbrd = 0; wbw = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 37; i++) begin
      apply(tbl[i], $sformatf("tbl[%0d]", i));
    end

    // RAW on x5: retire releases the consumer same cycle only with bypass
    apply(mk(1,1,1,0,0, 5,1,0,1,0, 0,0,0, 1,0,0,1,0,1), "raw_prod");
    apply(mk(1,5,1,1,1, 6,1,0,1,0, 0,0,0, 1,0,1,0,1,1), "raw_blk0");
    apply(mk(1,5,1,1,1, 6,1,0,1,0, 0,0,0, 1,0,1,0,1,1), "raw_blk1");
`ifdef SCB_WB_BYPASS_EN
    apply(mk(1,5,1,1,1, 6,1,0,1,0, 1,5,1, 1,0,0,1,1,1), "raw_wb");
`else
    apply(mk(1,5,1,1,1, 6,1,0,1,0, 1,5,1, 1,0,1,0,1,1), "raw_wb");
    apply(mk(1,5,1,1,1, 6,1,0,1,0, 0,0,0, 1,0,0,1,0,1), "raw_issue");
`endif
    apply(mk(0,0,0,0,0, 0,0,0,1,0, 1,6,1, 1,0,0,0,1,1), "raw_drain");

    // Reset taken while a serialising op is outstanding
    apply(mk(1,0,0,0,0, 12,1,1,1,0, 0,0,0, 1,0,0,1,0,1), "ser_issue");
    apply(mk(1,0,0,0,0, 13,1,0,1,0, 0,0,0, 1,0,1,0,1,1), "ser_hold");
    rst = 1'b1;
    v = 0; exen = 0; dw = 0; ser = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    apply(idle, "rst_state");
    apply(mk(1,12,1,0,0, 0,0,0,1,0, 0,0,0, 1,0,0,1,0,0), "rst_cleared");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
